pipe_reduce: RTL
================

# pipe_reduce

Pipelined, parametrised bit-reduction tree: the next generation of our registered wide-AND block. It reduces a `WIDTH`-bit vector to one bit using AND, OR, XOR or XNOR, chosen per sample, through a tree of `FANIN`-input registered stages. It adds valid tracking, a pipeline stall, and an in-flight indicator. It sits in wide-compare, all-ready and parity paths where a single-level reduction would not meet timing.

## Interface
- `WIDTH`, default 10: number of input bits; must be ≥ 1.
- `FANIN`, default 6: inputs per tree node (LUT-sized); must be ≥ 2.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `en` input, 1 bit: pipeline advance; when 0, every pipeline register holds its value.
- `in_valid` input, 1 bit: `a`/`mode` carry a sample this cycle.
- `mode` input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- `a` input, `WIDTH` bits: vector to reduce.
- `out_valid` output, 1 bit: `out` holds a result.
- `out` output, 1 bit: reduction result.
- `busy` output, 1 bit: at least one stage holds a valid sample.

## Operation
- Reset is asynchronous, active-high: single clock `clk`, reset `rst`.
- **Level count `L`.**
  - If `WIDTH` ≤ `FANIN`, `L` = 1.
  - Otherwise `L` = 1 + the level count for `ceil(WIDTH/FANIN)`.
  - Examples: (10,6) gives 2; (1,6) gives 1; (64,4) gives 3; (37,6) gives 3 (37 → 7 → 2 → 1).
  - Exposed as localparam `LATENCY` = `L`.
- **Stage k input.** Stage k takes `W_k` bits, with `W_0` = `WIDTH`. It pads up to `ceil(W_k/FANIN)*FANIN` bits with the identity element of the sample's mode:
  - AND: pad with 1.
  - OR, XOR, XNOR: pad with 0.
  - Padding is selected from the mode carried with that sample, not the live `mode` input.
- **Stage k nodes.** Each group of `FANIN` bits is reduced into one register bit:
  - AND reduces with AND.
  - OR reduces with OR.
  - XOR and XNOR both reduce with XOR.
- **Final stage.** For mode 11, the single result bit is inverted as it is written into `out`. No other stage inverts.
- **Sideband.** A 2-bit mode register and a valid bit travel alongside each stage's data.
- **Advance rule.** When `en`=1, every stage (data, mode, valid) loads from the stage before it. Stage 0 loads `a`, `mode` and `in_valid`.
- **Stall.** When `en`=0, nothing changes and the input sample is ignored. The upstream side must hold the sample, or drop `in_valid`.
- **Invalid samples.** Bubbles (`in_valid`=0) still move data registers but carry valid=0. Data registers are don't-care while their valid is 0.
- **`busy`.** OR of all stage valid bits, taken combinationally from registers.
- **Reset.** All valid bits, mode registers, data registers and `out` clear to 0. So after reset `out_valid`=0, `out`=0 and `busy`=0.
- **Reset mid-operation.** In-flight samples are discarded. No partial result appears after `rst` deasserts.

## Timing
- **Latency.** A sample accepted at edge t (`en`=1, `in_valid`=1) appears on `out`/`out_valid` after edge t+`L`-1. That is, `L` cycles of `en`=1 from input to output.
- **Throughput.** One sample per enabled cycle, with no bubbles inserted.
- **Stalls.** Latency is measured in enabled cycles. `en`=0 cycles extend it one for one, and `out`/`out_valid` hold through a stall.
- **Consecutive samples.** Samples with different modes never interact.
- **Boundary case `WIDTH`=1.** One stage, a single register. AND/OR/XOR give `a`; XNOR gives `~a`.
- **Timing path.** No combinational path from any input to any output.

## Test plan
1. **Defaults, AND (`WIDTH`=10, `FANIN`=6).**
   - Stimulus: `a`=10'h3FF, mode 00, `in_valid`=1, `en`=1.
   - Required: `out_valid`=1, `out`=1 two cycles later.
   - Then `a`=10'h3FE: `out`=0. This checks that pad bits do not mask bit 0.
2. **Mode mix, back-to-back.** Four samples, `a`=10'h001, with modes 00, 01, 10, 11 on consecutive cycles.
   - Required: outputs 0, 1, 1, 0 on consecutive cycles, with `out_valid` continuous.
3. **Stall.**
   - Stimulus: issue `a`=10'h3FF, mode 00. Drop `en` for 3 cycles after the first edge, then restore it.
   - Required: result 1 appears 3 cycles late; `busy` stays 1 throughout; `out_valid`=0 until then.
4. **Deep tree, parity (`WIDTH`=37, `FANIN`=6).**
   - Stimulus: `a` = all ones (odd popcount), mode 10.
   - Required: `out`=1 after exactly 3 cycles. The same `a` with mode 11 gives `out`=0.
   - Random vectors are checked against a reference model at latency 3.
5. **Reset mid-flight.**
   - Stimulus: with two valid samples in flight, assert `rst` asynchronously between edges.
   - Required: `out`, `out_valid` and `busy` go to 0 immediately. After release, no output until a new sample enters.
6. **`WIDTH`=1 boundary.**
   - Stimulus: `a`=1 with mode 11, then `a`=0 with mode 11.
   - Required: `out`=0, then 1, at latency 1.

Source files
------------

// File: rtl/pipe_reduce.sv
// Pipelined FANIN-ary reduction tree (AND/OR/XOR/XNOR chosen per sample) with
// valid/mode sideband, a global stall and an in-flight indicator.
module pipe_reduce #(
  parameter int WIDTH = 10,
  parameter int FANIN = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic             out,
  output logic             busy
);

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XNOR = 2'b11;

  // Vector width entering stage k (stage k produces width_at(k+1) bits).
  function automatic int width_at(input int k);
    int w;
    w = WIDTH;
    for (int i = 0; i < k; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  function automatic int num_levels();
    int w;
    int l;
    w = WIDTH;
    l = 1;
    while (w > FANIN) begin
      w = (w + FANIN - 1) / FANIN;
      l++;
    end
    return l;
  endfunction

  localparam int LATENCY = num_levels();

  logic [LATENCY-1:0] valid_vec;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    localparam int WI   = width_at(k);
    localparam int WO   = width_at(k + 1);
    localparam bit LAST = (k == LATENCY - 1);

    logic [WI-1:0]       in_data;
    logic [1:0]          in_mode;
    logic                in_vld;
    logic [WO*FANIN-1:0] padded;
    logic                invert;
    logic [WO-1:0]       data_d;
    logic [WO-1:0]       data_q;
    logic                valid_q;

    if (k == 0) begin : g_src
      assign in_data = a;
      assign in_mode = mode;
      assign in_vld  = in_valid;
    end else begin : g_src
      assign in_data = g_stage[k-1].data_q;
      assign in_mode = g_stage[k-1].g_fwd.mode_q;
      assign in_vld  = g_stage[k-1].valid_q;
    end

    always_comb begin
      // NOTE: every variable gets a full default before any partial overwrite so no latch is inferred.
      padded            = {(WO*FANIN){in_mode == MODE_AND}};
      padded[WI-1:0]    = in_data;
      invert            = LAST && (in_mode == MODE_XNOR);
      data_d            = '0;
      for (int j = 0; j < WO; j++) begin
        case (in_mode)
          MODE_AND: data_d[j] = &padded[j*FANIN +: FANIN];
          MODE_OR:  data_d[j] = |padded[j*FANIN +: FANIN];
          default:  data_d[j] = (^padded[j*FANIN +: FANIN]) ^ invert;
        endcase
      end
    end

    // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (en) begin
        data_q  <= data_d;
        valid_q <= in_vld;
      end
    end

    assign valid_vec[k] = valid_q;

    // The last stage has no consumer for its mode, so only inner stages carry one.
    if (!LAST) begin : g_fwd
      logic [1:0] mode_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     mode_q <= 2'b00;
        else if (en) mode_q <= in_mode;
      end
    end
  end

  assign out       = g_stage[LATENCY-1].data_q[0];
  assign out_valid = valid_vec[LATENCY-1];
  assign busy      = |valid_vec;

endmodule
